// File: rtl/ccd_frame_capture.sv
// Sensor capture stage: registers raw pixels and gates capture to whole frames.
// Produces pixel-valid with aligned X/Y coordinates and counts completed frames.
module ccd_frame_capture #(
    parameter int COLUMN_WIDTH = 1280
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [9:0]  iDATA,
    input  logic        iFVAL,
    input  logic        iLVAL,
    input  logic        iSTART,
    input  logic        iEND,
    output logic [9:0]  oDATA,
    output logic        oDVAL,
    output logic [10:0] oX_Cont,
    output logic [10:0] oY_Cont,
    output logic [31:0] oFrame_Cont,
    output logic        oBusy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACTIVE
    } state_t;

    localparam logic [10:0] X_LAST = 11'(COLUMN_WIDTH - 1);

    state_t      state_q, state_d;
    logic        run_q, run_d;
    logic [9:0]  d_data_q;
    logic        d_fval_q, d_lval_q, p_fval_q;
    logic [10:0] x_q, x_d, y_q, y_d;
    logic [10:0] x_cur, y_cur;
    logic        rise, fall, eligible, frame_done;

    always_comb begin
        rise       = d_fval_q & ~p_fval_q;
        fall       = ~d_fval_q & p_fval_q;
        run_d      = iEND ? 1'b0 : (iSTART ? 1'b1 : run_q);
        state_d    = state_q;
        frame_done = 1'b0;
        case (state_q)
            S_IDLE:   if (run_q) state_d = S_WAIT;
            S_WAIT: begin
                if (!run_q)    state_d = S_IDLE;
                else if (rise) state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (fall) begin
                    state_d    = run_q ? S_WAIT : S_IDLE;
                    frame_done = 1'b1;
                end
            end
            default:  state_d = S_IDLE;
        endcase

        // the rise cycle itself already counts as part of the captured frame
        eligible = d_fval_q && d_lval_q &&
                   ((state_q == S_ACTIVE) || ((state_q == S_WAIT) && (state_d == S_ACTIVE)));

        if ((state_q != S_ACTIVE) || rise) begin
            x_cur = '0;
            y_cur = '0;
        end else begin
            x_cur = x_q;
            y_cur = y_q;
        end

        x_d = x_cur;
        y_d = y_cur;
        if (eligible) begin
            if (x_cur == X_LAST) begin
                x_d = '0;
                y_d = y_cur + 11'd1;
            end else begin
                x_d = x_cur + 11'd1;
            end
        end
        if (state_d != S_ACTIVE) begin
            x_d = '0;
            y_d = '0;
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q     <= S_IDLE;
            run_q       <= 1'b0;
            d_data_q    <= '0;
            d_fval_q    <= 1'b0;
            d_lval_q    <= 1'b0;
            p_fval_q    <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            oDATA       <= '0;
            oDVAL       <= 1'b0;
            oX_Cont     <= '0;
            oY_Cont     <= '0;
            oFrame_Cont <= '0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            d_data_q    <= iDATA;
            d_fval_q    <= iFVAL;
            d_lval_q    <= iLVAL;
            p_fval_q    <= d_fval_q;
            x_q         <= x_d;
            y_q         <= y_d;
            oDATA       <= eligible ? d_data_q : '0;
            oDVAL       <= eligible;
            oX_Cont     <= x_cur;
            oY_Cont     <= y_cur;
            if (frame_done) oFrame_Cont <= oFrame_Cont + 32'd1;
        end
    end

    assign oBusy = (state_q != S_IDLE);

endmodule

// File: tb/tb_ccd_frame_capture.sv
// Scoreboard bench for ccd_frame_capture: two instances (4 and 8 columns) share stimulus;
// expected pixels come from the frame-level rule x = n mod width, y = n div width.
module tb_ccd_frame_capture;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b0;
    logic [9:0]  iDATA = '0;
    logic        iFVAL = 1'b0, iLVAL = 1'b0, iSTART = 1'b0, iEND = 1'b0;

    logic [9:0]  o4_data, o8_data;
    logic        o4_dval, o8_dval, o4_busy, o8_busy;
    logic [10:0] o4_x, o4_y, o8_x, o8_y;
    logic [31:0] o4_fc, o8_fc;

    typedef struct {
        logic [9:0] d;
        int         x;
        int         y;
    } px_t;

    px_t q4[$];
    px_t q8[$];
    int  cmp_n  = 0;
    int  err_n  = 0;
    int  fc_exp = 0;

    always #5 iCLK = ~iCLK;

    ccd_frame_capture #(.COLUMN_WIDTH(4)) u4 (
        .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iFVAL(iFVAL), .iLVAL(iLVAL),
        .iSTART(iSTART), .iEND(iEND), .oDATA(o4_data), .oDVAL(o4_dval),
        .oX_Cont(o4_x), .oY_Cont(o4_y), .oFrame_Cont(o4_fc), .oBusy(o4_busy)
    );

    ccd_frame_capture #(.COLUMN_WIDTH(8)) u8 (
        .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iFVAL(iFVAL), .iLVAL(iLVAL),
        .iSTART(iSTART), .iEND(iEND), .oDATA(o8_data), .oDVAL(o8_dval),
        .oX_Cont(o8_x), .oY_Cont(o8_y), .oFrame_Cont(o8_fc), .oBusy(o8_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_n++;
        if (act !== exp) begin
            err_n++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic push_px(input logic [9:0] d, input int n);
        q4.push_back('{d: d, x: n % 4, y: (n / 4) % 2048});
        q8.push_back('{d: d, x: n % 8, y: (n / 8) % 2048});
    endtask

    task automatic pulse_start();
        iSTART = 1'b1;
        tick();
        iSTART = 1'b0;
    endtask

    task automatic pulse_end();
        iEND = 1'b1;
        tick();
        iEND = 1'b0;
    endtask

    // One sensor frame. cap: whether the spec rules say it is captured.
    // start_after/end_after: line index after which iSTART/iEND is pulsed (-1 = never).
    task automatic frame(input int lines, input int width, input bit cap,
                         input int start_after, input int end_after,
                         input int gap_pos, input int gap_len);
        int n;
        int porch;
        n     = 0;
        porch = int'($urandom_range(0, 2));
        iFVAL = 1'b1;
        iLVAL = 1'b0;
        repeat (porch) tick();
        for (int l = 0; l < lines; l++) begin
            for (int p = 0; p < width; p++) begin
                if (p == gap_pos && gap_len > 0) begin
                    iLVAL = 1'b0;
                    iDATA = 10'($urandom);
                    repeat (gap_len) tick();
                end
                iLVAL = 1'b1;
                iDATA = 10'($urandom);
                if (cap) push_px(iDATA, n);
                n++;
                tick();
            end
            iLVAL = 1'b0;
            iDATA = 10'($urandom);
            tick();
            tick();
            if (l == start_after) pulse_start();
            if (l == end_after)   pulse_end();
        end
        // line valid still high as frame valid drops: must not be captured
        iFVAL = 1'b0;
        iLVAL = 1'b1;
        iDATA = 10'($urandom);
        tick();
        iLVAL = 1'b0;
        repeat (4) tick();
        if (cap) fc_exp++;
        check("u4_queue_drained", q4.size(), 0);
        check("u8_queue_drained", q8.size(), 0);
        check("u4_frame_count", o4_fc, fc_exp);
        check("u8_frame_count", o8_fc, fc_exp);
        q4.delete();
        q8.delete();
    endtask

    always @(negedge iCLK) begin
        if (iRST && o4_dval) begin
            if (q4.size() == 0) begin
                cmp_n++;
                err_n++;
                $display("FAIL u4_unexpected_dval: got data %0d at (%0d,%0d), expected no valid pixel",
                         o4_data, o4_x, o4_y);
            end else begin
                px_t e;
                e = q4.pop_front();
                check("u4_data", o4_data, e.d);
                check("u4_x", o4_x, e.x);
                check("u4_y", o4_y, e.y);
            end
        end
    end

    always @(negedge iCLK) begin
        if (iRST && o8_dval) begin
            if (q8.size() == 0) begin
                cmp_n++;
                err_n++;
                $display("FAIL u8_unexpected_dval: got data %0d at (%0d,%0d), expected no valid pixel",
                         o8_data, o8_x, o8_y);
            end else begin
                px_t e;
                e = q8.pop_front();
                check("u8_data", o8_data, e.d);
                check("u8_x", o8_x, e.x);
                check("u8_y", o8_y, e.y);
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) tick();
        check("rst_data", o4_data, 0);
        check("rst_dval", o4_dval, 0);
        check("rst_x", o4_x, 0);
        check("rst_y", o4_y, 0);
        check("rst_fc", o4_fc, 0);
        check("rst_busy", o4_busy, 0);
        iRST = 1'b1;
        tick();

        // basic frame; FVAL rises right after WAIT is entered
        pulse_start();
        check("busy_one_edge_after_start", o4_busy, 0);
        frame(3, 4, 1'b1, -1, -1, -1, 0);
        check("busy_wait_after_frame", o4_busy, 1);

        // iSTART mid-frame: that frame skipped, next one captured
        pulse_end();
        tick();
        tick();
        check("busy_idle_after_end", o4_busy, 0);
        frame(3, 4, 1'b0, 0, -1, -1, 0);
        check("busy_wait_after_midframe_start", o4_busy, 1);
        frame(3, 4, 1'b1, -1, -1, -1, 0);

        // iEND after line 0: frame completes, then idle, next frame ignored
        frame(3, 4, 1'b1, -1, 0, -1, 0);
        check("busy_idle_after_end_midframe", o4_busy, 0);
        frame(2, 4, 1'b0, -1, -1, -1, 0);
        check("busy_still_idle", o4_busy, 0);

        // iSTART and iEND together: iEND wins
        iSTART = 1'b1;
        iEND   = 1'b1;
        tick();
        iSTART = 1'b0;
        iEND   = 1'b0;
        repeat (3) tick();
        check("busy_start_end_same_cycle", o4_busy, 0);
        frame(1, 4, 1'b0, -1, -1, -1, 0);

        // 8 pixels split 3+5 by a 5-cycle line-valid gap
        pulse_start();
        tick();
        tick();
        check("busy_wait_before_gap_frame", o4_busy, 1);
        frame(1, 8, 1'b1, -1, -1, 3, 5);

        // randomized captured frames (widths may exceed 4 or 8 columns)
        for (int k = 0; k < 6; k++) begin
            int w;
            w = int'($urandom_range(1, 10));
            frame(int'($urandom_range(1, 4)), w, 1'b1, -1, -1,
                  int'($urandom_range(0, w - 1)), int'($urandom_range(0, 3)));
        end

        // asynchronous reset while pixel (2,1) of the 4-column instance is presented
        iFVAL = 1'b1;
        iLVAL = 1'b0;
        tick();
        for (int n = 0; n < 8; n++) begin
            iLVAL = 1'b1;
            iDATA = 10'($urandom);
            if (n <= 5) push_px(iDATA, n);
            tick();
        end
        #1;
        check("pre_rst_dval", o4_dval, 1);
        check("pre_rst_x", o4_x, 2);
        check("pre_rst_y", o4_y, 1);
        check("pre_rst_queue_drained", q4.size(), 0);
        iRST = 1'b0;
        #1;
        check("async_rst_data", o4_data, 0);
        check("async_rst_dval", o4_dval, 0);
        check("async_rst_x", o4_x, 0);
        check("async_rst_y", o4_y, 0);
        check("async_rst_fc", o4_fc, 0);
        check("async_rst_busy", o4_busy, 0);
        check("async_rst_u8_dval", o8_dval, 0);
        q4.delete();
        q8.delete();
        fc_exp = 0;
        iFVAL = 1'b0;
        iLVAL = 1'b0;
        repeat (2) tick();
        iRST = 1'b1;
        tick();
        frame(2, 4, 1'b0, -1, -1, -1, 0);
        pulse_start();
        tick();
        frame(3, 4, 1'b1, -1, -1, -1, 0);
        check("fc_one_after_reset", o4_fc, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end

endmodule

// File: doc/ccd_frame_capture.md
# ccd_frame_capture

Sensor-side capture stage that feeds the Bayer demosaic stage. Registers raw 10-bit sensor data with its frame-valid/line-valid strobes, gates capture to whole frames under iSTART/iEND control, and produces a pixel-valid strobe with aligned X/Y coordinates. Also maintains a completed-frame counter. oDATA, oDVAL, oX_Cont and oY_Cont connect directly to the demosaic stage's iDATA, iDVAL, iX_Cont and iY_Cont.

## Interface
- COLUMN_WIDTH, 1280: active pixels per line; X wraps to 0 after COLUMN_WIDTH-1.
- iCLK  in  1  pixel clock; all logic on rising edge.
- iRST  in  1  asynchronous, active-low reset.
- iDATA  in  10  raw sensor pixel.
- iFVAL  in  1  sensor frame valid.
- iLVAL  in  1  sensor line valid; meaningful only while iFVAL=1.
- iSTART  in  1  level/pulse; sets run flag.
- iEND  in  1  level/pulse; clears run flag.
- oDATA  out  10  captured pixel; 0 when oDVAL=0.
- oDVAL  out  1  pixel valid.
- oX_Cont  out  11  column of pixel on oDATA.
- oY_Cont  out  11  row of pixel on oDATA.
- oFrame_Cont  out  32  number of fully captured frames, wraps mod 2^32.
- oBusy  out  1  1 when the FSM is not IDLE.

## Operation
- Stage 1 registers iDATA, iFVAL, iLVAL (d_data, d_fval, d_lval). Also keeps a copy of the previous d_fval (p_fval). Frame edges are detected only from these registers.
  - Rise: d_fval=1 and p_fval=0.
  - Fall: d_fval=0 and p_fval=1.
- Run flag: iSTART=1 sets it and iEND=1 clears it. If both are 1 in the same cycle, iEND wins.
- FSM states and transitions:
  - IDLE: run=1 → WAIT.
  - WAIT: run=0 → IDLE. Otherwise, on rise → ACTIVE. A frame already in progress is never captured partially.
  - ACTIVE: on fall → WAIT if run=1, else IDLE. Clearing run mid-frame does not abort the frame; the frame completes first.
- Eligible pixel: FSM in ACTIVE (including the rise cycle itself) and d_fval=1 and d_lval=1.
- Coordinates, per eligible pixel:
  - The pixel is presented with the current X/Y.
  - Then X increments. When X=COLUMN_WIDTH-1, X goes to 0 and Y increments.
  - Y is 11-bit and wraps mod 2048.
  - X and Y hold while d_lval=0 inside a frame.
  - X and Y are forced to 0 on every rise and whenever the FSM is not ACTIVE.
- Output stage (registered):
  - oDVAL = eligible.
  - oDATA = eligible ? d_data : 0.
  - oX_Cont and oY_Cont = the coordinate of that pixel.
- oFrame_Cont increments by 1 on each ACTIVE→(WAIT|IDLE) transition, i.e. on each completed frame. It does not increment when a frame is skipped in WAIT.

## Timing
- Reset values:
  - oDATA=0, oDVAL=0, oX_Cont=0, oY_Cont=0, oFrame_Cont=0, oBusy=0.
  - Run flag=0, FSM=IDLE.
  - Stage-1 registers and p_fval=0.
- Latency: iDATA/iLVAL sampled at edge n appears on oDATA/oDVAL after edge n+1 (2 register stages).
- oX_Cont/oY_Cont are cycle-aligned with oDATA/oDVAL. The first valid pixel of every captured frame shows X=0, Y=0.
- iSTART asserted at edge n: run=1 after n, FSM=WAIT after n+1. oBusy follows the FSM with no extra delay.
- Rise and fall are evaluated on the 1-cycle-delayed FVAL. A frame whose iFVAL rises in the cycle right after WAIT is entered is captured.
- iFVAL falling while iLVAL=1: pixels with d_fval=0 are not eligible; the frame ends on fall.
- Asynchronous reset mid-frame: all state clears immediately. After release, capture requires a new iSTART and a new rise.
- Line longer than COLUMN_WIDTH: X wraps and Y advances mid-line (no error flag).

## Test plan
- Reset, then COLUMN_WIDTH=4, iSTART pulse, then one frame of 3 lines × 4 pixels with iDATA=ramp 1..12 → 12 oDVAL pulses.
  - oDATA 1..12.
  - (X,Y) = (0,0)…(3,0),(0,1)…(3,2).
  - oFrame_Cont=1 after FVAL falls; FSM back in WAIT.
- iSTART asserted while iFVAL=1 mid-frame → no oDVAL for the rest of that frame; next frame captured fully; oFrame_Cont increments once.
- iEND pulsed after line 1 of an ACTIVE frame → remaining lines still output, then FSM→IDLE, oBusy=0; the following frame produces no oDVAL.
- iSTART=iEND=1 same cycle from IDLE → run stays 0, FSM stays IDLE, oBusy=0.
- iLVAL gap of 5 cycles mid-line (COLUMN_WIDTH=8, 8 pixels split 3+5) → X continues 3..7 after the gap, oDVAL=0 during the gap, Y unchanged.
- iRST low during pixel X=2,Y=1 → all outputs 0 within the same cycle. After release with iSTART, the next frame starts at (0,0) with oFrame_Cont=1 when it completes.
